sent_rx_pulse_decode: RTL and testbench

Receive-side front end for the SENT link, downstream of `sent_tx_top`. It samples the `data_pulse` line and measures the time between falling edges in SENT ticks. It classifies each interval as sync, nibble or pause, and emits decoded nibbles tagged with their frame position. CRC checking and serial/enhanced message assembly belong to the next stage (`sent_rx_control`), which consumes these nibbles.

---
 rtl/sent_rx_pulse_decode.sv | 233 +++++++++++++++++++++++
 tb/tb_sent_rx_pulse_decode.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sent_rx_pulse_decode.sv
// SENT receive front end: measures falling-edge spacing in ticks, classifies
// sync / nibble / pause intervals and emits position-tagged nibbles.
module sent_rx_pulse_decode #(
  parameter int TICK_DIV = 10,
  parameter int NUM_DATA = 6
) (
  input  logic       clk_rx,
  input  logic       reset_rx,
  input  logic       enable,
  input  logic       data_pulse,
  output logic [3:0] nibble_out,
  output logic       nibble_valid,
  output logic [2:0] nibble_idx,
  output logic       sync_pulse,
  output logic       frame_done,
  output logic       pulse_error
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2);
  localparam logic [9:0]       TICK_MAX = 10'd1023;
  localparam logic [2:0]       LAST_DATA = 3'(NUM_DATA);

  typedef enum logic [2:0] {
    S_WAIT_SYNC,
    S_STATUS,
    S_DATA,
    S_CRC,
    S_AFTER_CRC,
    S_PAUSED
  } state_t;

  logic             sync1_q, sync2_q, prev_q, fall_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       tick_cnt_q, tick_cnt_d;
  logic             armed_q, armed_d;
  logic             meas_valid, timeout_hit;
  logic [10:0]      interval;
  logic             is_sync, is_nib, is_pause;
  logic [3:0]       nib_value;

  state_t           state_q, state_d;
  logic [2:0]       dcnt_q, dcnt_d;

  logic [3:0]       nibble_out_q, nibble_out_d;
  logic [2:0]       nibble_idx_q, nibble_idx_d;
  logic             nibble_valid_q, nibble_valid_d;
  logic             sync_pulse_q, sync_pulse_d;
  logic             frame_done_q, frame_done_d;
  logic             pulse_error_q, pulse_error_d;

  // Line idles high, so the synchronizer resets to 1 to avoid a false edge.
  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= data_pulse;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fall_q  <= prev_q & ~sync2_q;
    end
  end

  always_comb begin
    div_cnt_d   = div_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    armed_d     = armed_q;
    meas_valid  = 1'b0;
    timeout_hit = 1'b0;
    if (!enable) begin
      div_cnt_d  = '0;
      tick_cnt_d = '0;
      armed_d    = 1'b0;
    end else if (fall_q) begin
      div_cnt_d  = '0;
      tick_cnt_d = '0;
      armed_d    = 1'b1;
      meas_valid = armed_q;
    end else if (tick_cnt_q == TICK_MAX) begin
      // Saturated: counters freeze until the next edge, timeout fires once.
      timeout_hit = armed_q;
      armed_d     = 1'b0;
    end else if (div_cnt_q == DIV_MAX) begin
      div_cnt_d  = '0;
      tick_cnt_d = tick_cnt_q + 10'd1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    interval  = {1'b0, tick_cnt_q} + 11'((div_cnt_q >= DIV_HALF) ? 1 : 0);
    is_sync   = (interval == 11'd56);
    is_nib    = (interval >= 11'd12) && (interval <= 11'd27);
    is_pause  = (interval >= 11'd12) && (interval <= 11'd768) && !is_sync;
    nib_value = 4'(interval - 11'd12);
  end

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      state_q <= S_WAIT_SYNC;
      dcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (!enable || timeout_hit) begin
      state_d = S_WAIT_SYNC;
    end else if (meas_valid) begin
      case (state_q)
        S_WAIT_SYNC: begin
          if (is_sync) state_d = S_STATUS;
        end
        S_STATUS, S_DATA, S_CRC: begin
          if (is_nib) begin
            if (state_q == S_STATUS) begin
              state_d = S_DATA;
              dcnt_d  = 3'd1;
            end else if (state_q == S_DATA) begin
              if (dcnt_q == LAST_DATA) state_d = S_CRC;
              else                     dcnt_d  = dcnt_q + 3'd1;
            end else begin
              state_d = S_AFTER_CRC;
            end
          end else if (is_sync) begin
            state_d = S_STATUS;
          end else begin
            state_d = S_WAIT_SYNC;
          end
        end
        S_AFTER_CRC: begin
          if (is_sync)       state_d = S_STATUS;
          else if (is_pause) state_d = S_PAUSED;
          else               state_d = S_WAIT_SYNC;
        end
        S_PAUSED: begin
          if (is_sync) state_d = S_STATUS;
          else         state_d = S_WAIT_SYNC;
        end
        default: state_d = S_WAIT_SYNC;
      endcase
    end
  end

  always_comb begin
    nibble_out_d   = nibble_out_q;
    nibble_idx_d   = nibble_idx_q;
    nibble_valid_d = 1'b0;
    sync_pulse_d   = 1'b0;
    frame_done_d   = 1'b0;
    pulse_error_d  = 1'b0;
    if (enable && timeout_hit) begin
      pulse_error_d = 1'b1;
    end else if (enable && meas_valid) begin
      case (state_q)
        S_WAIT_SYNC: begin
          sync_pulse_d = is_sync;
        end
        S_STATUS, S_DATA, S_CRC: begin
          if (is_nib) begin
            nibble_valid_d = 1'b1;
            nibble_out_d   = nib_value;
            if (state_q == S_STATUS)    nibble_idx_d = 3'd0;
            else if (state_q == S_DATA) nibble_idx_d = dcnt_q;
            else begin
              nibble_idx_d = 3'd7;
              frame_done_d = 1'b1;
            end
          end else begin
            pulse_error_d = 1'b1;
            sync_pulse_d  = is_sync;
          end
        end
        S_AFTER_CRC: begin
          sync_pulse_d  = is_sync;
          pulse_error_d = !is_sync && !is_pause;
        end
        S_PAUSED: begin
          sync_pulse_d  = is_sync;
          pulse_error_d = !is_sync;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      nibble_out_q   <= 4'd0;
      nibble_idx_q   <= 3'd0;
      nibble_valid_q <= 1'b0;
      sync_pulse_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      pulse_error_q  <= 1'b0;
    end else begin
      nibble_out_q   <= nibble_out_d;
      nibble_idx_q   <= nibble_idx_d;
      nibble_valid_q <= nibble_valid_d;
      sync_pulse_q   <= sync_pulse_d;
      frame_done_q   <= frame_done_d;
      pulse_error_q  <= pulse_error_d;
    end
  end

  assign nibble_out   = nibble_out_q;
  assign nibble_idx   = nibble_idx_q;
  assign nibble_valid = nibble_valid_q;
  assign sync_pulse   = sync_pulse_q;
  assign frame_done   = frame_done_q;
  assign pulse_error  = pulse_error_q;

endmodule

// File: tb/tb_sent_rx_pulse_decode.sv
// Scoreboard bench for sent_rx_pulse_decode: a protocol-level model predicts
// the strobes for every falling-edge interval; a monitor pops and compares.
module tb_sent_rx_pulse_decode;

  localparam int TD = 10;
  localparam int ND = 6;
  localparam int LOW_CLKS = 30;

  logic       clk_rx = 1'b0;
  logic       reset_rx;
  logic       enable;
  logic       data_pulse;
  logic [3:0] nibble_out;
  logic       nibble_valid;
  logic [2:0] nibble_idx;
  logic       sync_pulse;
  logic       frame_done;
  logic       pulse_error;

  sent_rx_pulse_decode #(.TICK_DIV(TD), .NUM_DATA(ND)) dut (
    .clk_rx      (clk_rx),
    .reset_rx    (reset_rx),
    .enable      (enable),
    .data_pulse  (data_pulse),
    .nibble_out  (nibble_out),
    .nibble_valid(nibble_valid),
    .nibble_idx  (nibble_idx),
    .sync_pulse  (sync_pulse),
    .frame_done  (frame_done),
    .pulse_error (pulse_error)
  );

  always #5 clk_rx = ~clk_rx;

  typedef struct {
    bit nv;
    int nib;
    int idx;
    bit sy;
    bit fd;
    bit er;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Model: pos -1 = hunting for sync, 0 = status next, 1..ND = data next,
  // ND+1 = CRC next, 100 = just after CRC, 101 = after a pause.
  int   pos = -1;
  bit   armed = 0;
  int   last_ticks = 0;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input bit nv, input int nib, input int idx,
                         input bit sy, input bit fd, input bit er);
    exp_t e;
    e.nv = nv; e.nib = nib; e.idx = idx; e.sy = sy; e.fd = fd; e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic model_interval(input int t);
    bit is_s, is_n, is_p;
    is_s = (t == 56);
    is_n = (t >= 12 && t <= 27);
    is_p = (t >= 12 && t <= 768 && !is_s);
    if (pos == -1) begin
      if (is_s) begin push_ev(0, 0, 0, 1, 0, 0); pos = 0; end
    end else if (pos <= ND + 1) begin
      if (is_n) begin
        if (pos == ND + 1) begin push_ev(1, t - 12, 7, 0, 1, 0); pos = 100; end
        else begin push_ev(1, t - 12, pos, 0, 0, 0); pos = pos + 1; end
      end else if (is_s) begin
        push_ev(0, 0, 0, 1, 0, 1); pos = 0;
      end else begin
        push_ev(0, 0, 0, 0, 0, 1); pos = -1;
      end
    end else if (pos == 100) begin
      if (is_s)      begin push_ev(0, 0, 0, 1, 0, 0); pos = 0; end
      else if (is_p) pos = 101;
      else           begin push_ev(0, 0, 0, 0, 0, 1); pos = -1; end
    end else begin
      if (is_s) begin push_ev(0, 0, 0, 1, 0, 0); pos = 0; end
      else      begin push_ev(0, 0, 0, 0, 0, 1); pos = -1; end
    end
  endtask

  // One falling edge, then the line waits ticks*TD+off clocks until the next.
  task automatic applyStimulus(input int ticks, input int off);
    @(negedge clk_rx);
    data_pulse = 1'b0;
    if (armed) model_interval(last_ticks);
    else       armed = 1;
    last_ticks = ticks;
    if (ticks > 1023) begin
      push_ev(0, 0, 0, 0, 0, 1);
      armed = 0;
      pos = -1;
    end
    repeat (LOW_CLKS) @(negedge clk_rx);
    data_pulse = 1'b1;
    repeat (ticks * TD + off - LOW_CLKS - 1) @(negedge clk_rx);
  endtask

  task automatic drop_enable(input int clks);
    @(negedge clk_rx);
    enable = 1'b0;
    armed = 0;
    pos = -1;
    repeat (clks) @(negedge clk_rx);
    enable = 1'b1;
  endtask

  function automatic int rand_off();
    return int'($urandom_range(0, 8)) - 4;
  endfunction

  always @(negedge clk_rx) begin
    exp_t e;
    if (!reset_rx && (nibble_valid || sync_pulse || frame_done || pulse_error)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_strobe valid=%0b sync=%0b done=%0b err=%0b required none at %0t",
                 nibble_valid, sync_pulse, frame_done, pulse_error, $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("nibble_valid", int'(nibble_valid), int'(e.nv));
        checkOutput("sync_pulse",   int'(sync_pulse),   int'(e.sy));
        checkOutput("frame_done",   int'(frame_done),   int'(e.fd));
        checkOutput("pulse_error",  int'(pulse_error),  int'(e.er));
        if (e.nv) begin
          checkOutput("nibble_out", int'(nibble_out), e.nib);
          checkOutput("nibble_idx", int'(nibble_idx), e.idx);
        end
      end
    end
  end

  int dir_t[$] = '{56, 12, 13, 14, 15, 16, 17, 27, 20, 100, 56,
                   12, 13, 14, 15, 16, 17, 27, 20, 100, 30,
                   56, 12, 13, 30,
                   56, 12, 13, 56, 12, 13, 14, 15, 16, 17, 27, 20,
                   56, 56, 55, 56, 12};
  int dir_o[$] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   -4, 4, 4, 0, 0};

  initial begin
    reset_rx   = 1'b1;
    enable     = 1'b1;
    data_pulse = 1'b1;
    repeat (3) @(negedge clk_rx);
    checkOutput("reset_nibble_valid", int'(nibble_valid), 0);
    checkOutput("reset_sync_pulse",   int'(sync_pulse),   0);
    checkOutput("reset_pulse_error",  int'(pulse_error),  0);
    checkOutput("reset_frame_done",   int'(frame_done),   0);
    checkOutput("reset_nibble_out",   int'(nibble_out),   0);
    checkOutput("reset_nibble_idx",   int'(nibble_idx),   0);
    reset_rx = 1'b0;
    repeat (4) @(negedge clk_rx);

    // Directed: clean frames, pause, illegal nibbles, resync, rounding edges.
    for (int i = 0; i < dir_t.size(); i++) applyStimulus(dir_t[i], dir_o[i]);

    // Enable dropped mid-DATA, then re-armed and resynchronised.
    applyStimulus(56, 0);
    applyStimulus(12, 0);
    applyStimulus(13, 0);
    drop_enable(20);
    applyStimulus(56, 0);
    applyStimulus(12, 0);
    applyStimulus(13, 0);

    // Timeout: line held high well beyond 1023 ticks after an armed edge.
    applyStimulus(1100, 0);
    applyStimulus(56, 0);

    // Randomised frames with occasional corrupted intervals.
    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < ND + 3; n++) begin
        int t;
        if (n == 0) t = 56;
        else        t = 12 + int'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) t = int'($urandom_range(5, 800));
        applyStimulus(t, rand_off());
      end
      if ($urandom_range(0, 1) == 1) applyStimulus(12 + int'($urandom_range(0, 300)), rand_off());
    end
    applyStimulus(56, 0);
    applyStimulus(12, 0);

    repeat (20) @(negedge clk_rx);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
